// File: rtl/seq_result_ctrl.sv
// rtl/seq_result_ctrl.sv - key-driven launch/collect sequencer between PS/2 decoder, compute FSM and display
module seq_result_ctrl #(
    parameter int DEPTH   = 10,
    parameter int DATA_W  = 32,
    parameter int IN_W    = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [2:0]        key_flags,
    input  logic [4:0]        key_code,
    output logic              fsm_start,
    output logic [IN_W-1:0]   fsm_data,
    output logic              fsm_reset,
    input  logic              fsm_ready,
    input  logic [1:0]        fsm_err,
    input  logic [DATA_W-1:0] fsm_result,
    output logic [DATA_W-1:0] disp_value,
    output logic [3:0]        disp_index,
    output logic [3:0]        count,
    output logic [1:0]        err_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]     DEPTH_C = 4'(DEPTH);

    state_t              state;
    state_t              state_nx;
    logic [IN_W-1:0]     operand;
    logic [CNT_W-1:0]    wait_cnt;
    logic                keep_err;
    logic [DATA_W-1:0]   res_mem [16];

    logic flag_enter;
    logic flag_cmd;
    logic is_enter;
    logic is_digit;
    logic cmd_next;
    logic cmd_clear;
    logic full;
    logic timeout_hit;

    assign flag_enter  = (key_flags == 3'b010);
    assign flag_cmd    = (key_flags == 3'b100);
    assign is_enter    = key_valid && flag_enter;
    assign is_digit    = key_valid && !flag_enter && !flag_cmd;
    assign cmd_next    = key_valid && flag_cmd && (key_code == 5'b10000);
    assign cmd_clear   = key_valid && flag_cmd && (key_code == 5'b10001);
    assign full        = (count == DEPTH_C);
    assign timeout_hit = (state == S_WAIT) && !fsm_ready && (wait_cnt == TO_LAST);

    assign disp_value  = (count == 4'd0) ? '0 : res_mem[disp_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // CLEAR command wins over every state, including an in-flight WAIT.
    always_comb begin
        state_nx = state;
        if (cmd_clear) begin
            state_nx = S_CLEAR;
        end else begin
            case (state)
                S_IDLE:   if (is_enter && !full) state_nx = S_LAUNCH;
                S_LAUNCH: state_nx = S_WAIT;
                S_WAIT: begin
                    if (fsm_ready)
                        state_nx = S_IDLE;
                    else if (wait_cnt == TO_LAST)
                        state_nx = S_CLEAR;
                end
                S_CLEAR:  state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fsm_start = 1'b0;
        fsm_reset = 1'b0;
        busy      = 1'b0;
        case (state)
            S_LAUNCH: begin
                fsm_start = 1'b1;
                busy      = 1'b1;
            end
            S_WAIT:   busy      = 1'b1;
            S_CLEAR:  fsm_reset = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            operand    <= '0;
            fsm_data   <= '0;
            count      <= 4'd0;
            disp_index <= 4'd0;
            err_out    <= 2'b00;
            wait_cnt   <= '0;
            keep_err   <= 1'b0;
            for (int i = 0; i < 16; i++) res_mem[i] <= '0;
        end else if (state == S_CLEAR) begin
            // A timeout-driven clear keeps the fault code visible afterwards.
            operand    <= '0;
            count      <= 4'd0;
            disp_index <= 4'd0;
            err_out    <= keep_err ? 2'b11 : 2'b00;
            keep_err   <= 1'b0;
            for (int i = 0; i < 16; i++) res_mem[i] <= '0;
        end else begin
            // Pointer wrap looks at the count before any same-cycle store.
            if (cmd_next) begin
                if (count == 4'd0 || disp_index == count - 4'd1)
                    disp_index <= 4'd0;
                else
                    disp_index <= disp_index + 4'd1;
            end

            if (state == S_IDLE) begin
                if (is_digit)
                    operand <= {operand[IN_W-5:0], key_code[3:0]};
                if (is_enter) begin
                    if (full)
                        err_out <= 2'b11;
                    else
                        fsm_data <= operand;
                end
            end

            if (state == S_LAUNCH)
                wait_cnt <= '0;

            if (state == S_WAIT && !cmd_clear) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (fsm_ready) begin
                    if (fsm_err == 2'b00) begin
                        if (!full) begin
                            res_mem[count] <= fsm_result;
                            count          <= count + 4'd1;
                        end
                    end else begin
                        err_out <= fsm_err;
                    end
                end else if (timeout_hit) begin
                    err_out  <= 2'b11;
                    keep_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_result_ctrl.sv
// tb/tb_seq_result_ctrl.sv - vector table, corner sequences and random ops against a transaction-level model
module tb_seq_result_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [2:0]  key_flags;
    logic [4:0]  key_code;
    logic        fsm_start;
    logic [15:0] fsm_data;
    logic        fsm_reset;
    logic        fsm_ready;
    logic [1:0]  fsm_err;
    logic [31:0] fsm_result;
    logic [31:0] disp_value;
    logic [3:0]  disp_index;
    logic [3:0]  count;
    logic [1:0]  err_out;
    logic        busy;

    seq_result_ctrl #(.DEPTH(10), .DATA_W(32), .IN_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_flags(key_flags),
        .key_code(key_code), .fsm_start(fsm_start), .fsm_data(fsm_data),
        .fsm_reset(fsm_reset), .fsm_ready(fsm_ready), .fsm_err(fsm_err),
        .fsm_result(fsm_result), .disp_value(disp_value), .disp_index(disp_index),
        .count(count), .err_out(err_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int resets = 0;

    always @(posedge clk) begin
        if (fsm_start) starts++;
        if (fsm_reset) resets++;
    end

    // model: a list of stored results, a pointer, an error code and the operand
    logic [31:0] m_buf [16];
    int          m_count;
    int          m_idx;
    logic [1:0]  m_err;
    logic [15:0] m_oper;

    typedef struct {
        int          op;     // 0 enter+respond, 1 next, 2 clear
        logic [1:0]  err;
        logic [31:0] res;
        int          ec;
        int          ei;
        logic [1:0]  ee;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_clear();
        m_count = 0;
        m_idx   = 0;
        m_err   = 2'b00;
        m_oper  = 16'h0;
        for (int i = 0; i < 16; i++) m_buf[i] = 32'h0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".idx"}, 32'(disp_index), 32'(m_idx));
        chk({tag, ".err"}, 32'(err_out), 32'(m_err));
        chk({tag, ".disp"}, disp_value, (m_count == 0) ? 32'h0 : m_buf[m_idx]);
    endtask

    task automatic press(input logic [2:0] f, input logic [4:0] c);
        key_valid = 1'b1;
        key_flags = f;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_flags = 3'b000;
        key_code  = 5'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        press(3'b000, {1'b0, d});
        m_oper = {m_oper[11:0], d};
    endtask

    task automatic next_key();
        press(3'b100, 5'b10000);
        if (m_count == 0 || m_idx == m_count - 1) m_idx = 0;
        else m_idx = m_idx + 1;
    endtask

    task automatic clear_key();
        int r0;
        r0 = resets;
        press(3'b100, 5'b10001);
        @(negedge clk);
        chk("clear.reset_pulse", 32'(resets), 32'(r0 + 1));
        m_clear();
    endtask

    task automatic do_enter(input logic [1:0] e, input logic [31:0] res, input int delay);
        int s0;
        s0 = starts;
        press(3'b010, 5'b0);
        if (m_count == 10) begin
            @(negedge clk);
            chk("full.no_start", 32'(starts), 32'(s0));
            chk("full.busy", 32'(busy), 32'(0));
            m_err = 2'b11;
            return;
        end
        chk("enter.start", 32'(fsm_start), 32'(1));
        chk("enter.data", 32'(fsm_data), 32'(m_oper));
        @(negedge clk);
        repeat (delay) @(negedge clk);
        fsm_ready  = 1'b1;
        fsm_err    = e;
        fsm_result = res;
        @(negedge clk);
        fsm_ready  = 1'b0;
        fsm_err    = 2'b00;
        fsm_result = 32'h0;
        chk("enter.one_start", 32'(starts), 32'(s0 + 1));
        chk("enter.busy_off", 32'(busy), 32'(0));
        if (e == 2'b00) begin
            m_buf[m_count] = res;
            m_count++;
        end else begin
            m_err = e;
        end
    endtask

    initial begin
        int s0;
        int r0;
        int bc;
        int guard;

        reset = 1'b1;
        key_valid = 1'b0; key_flags = 3'b000; key_code = 5'b0;
        fsm_ready = 1'b0; fsm_err = 2'b00; fsm_result = 32'h0;
        m_clear();
        repeat (3) @(negedge clk);
        chk("rst.count", 32'(count), 32'(0));
        chk("rst.idx", 32'(disp_index), 32'(0));
        chk("rst.err", 32'(err_out), 32'(0));
        chk("rst.disp", disp_value, 32'h0);
        chk("rst.data", 32'(fsm_data), 32'(0));
        chk("rst.ctl", {29'h0, busy, fsm_start, fsm_reset}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        tbl[0]  = '{0, 2'b00, 32'hDEAD0001, 1, 0, 2'b00, 32'hDEAD0001};
        tbl[1]  = '{0, 2'b10, 32'h0,        1, 0, 2'b10, 32'hDEAD0001};
        tbl[2]  = '{0, 2'b00, 32'h00000002, 2, 0, 2'b10, 32'hDEAD0001};
        tbl[3]  = '{0, 2'b00, 32'h00000003, 3, 0, 2'b10, 32'hDEAD0001};
        tbl[4]  = '{1, 2'b00, 32'h0,        3, 1, 2'b10, 32'h00000002};
        tbl[5]  = '{1, 2'b00, 32'h0,        3, 2, 2'b10, 32'h00000003};
        tbl[6]  = '{1, 2'b00, 32'h0,        3, 0, 2'b10, 32'hDEAD0001};
        tbl[7]  = '{1, 2'b00, 32'h0,        3, 1, 2'b10, 32'h00000002};
        tbl[8]  = '{0, 2'b01, 32'h0,        3, 1, 2'b01, 32'h00000002};
        tbl[9]  = '{2, 2'b00, 32'h0,        0, 0, 2'b00, 32'h0};
        tbl[10] = '{1, 2'b00, 32'h0,        0, 0, 2'b00, 32'h0};
        tbl[11] = '{0, 2'b00, 32'h0000ABCD, 1, 0, 2'b00, 32'h0000ABCD};

        for (int i = 0; i < 12; i++) begin
            case (tbl[i].op)
                0:       do_enter(tbl[i].err, tbl[i].res, i % 3);
                1:       next_key();
                default: clear_key();
            endcase
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].ec));
            chk($sformatf("vec%0d.idx", i), 32'(disp_index), 32'(tbl[i].ei));
            chk($sformatf("vec%0d.err", i), 32'(err_out), 32'(tbl[i].ee));
            chk($sformatf("vec%0d.disp", i), disp_value, tbl[i].ed);
        end

        // operand assembly and held launch data
        clear_key();
        digit(4'h1); digit(4'h2); digit(4'hA); digit(4'hF);
        s0 = starts;
        press(3'b010, 5'b0);
        chk("seq1.start", 32'(fsm_start), 32'(1));
        chk("seq1.data", 32'(fsm_data), 32'h12AF);
        digit(4'h7);
        m_oper = 16'h12AF;
        repeat (3) begin
            chk("seq1.busy", 32'(busy), 32'(1));
            chk("seq1.hold", 32'(fsm_data), 32'h12AF);
            @(negedge clk);
        end
        chk("seq1.single_start", 32'(starts), 32'(s0 + 1));
        fsm_ready = 1'b1; fsm_result = 32'h0BADF00D;
        @(negedge clk);
        fsm_ready = 1'b0; fsm_result = 32'h0;
        m_buf[0] = 32'h0BADF00D; m_count = 1;
        chk("seq1.busy_off", 32'(busy), 32'(0));
        check_model("seq1");

        // NEXT on the same cycle as a store wraps on the old count
        s0 = starts;
        press(3'b010, 5'b0);
        @(negedge clk);
        fsm_ready = 1'b1; fsm_result = 32'h00000022;
        key_valid = 1'b1; key_flags = 3'b100; key_code = 5'b10000;
        @(negedge clk);
        fsm_ready = 1'b0; fsm_result = 32'h0;
        key_valid = 1'b0; key_flags = 3'b000; key_code = 5'b0;
        m_buf[1] = 32'h00000022; m_count = 2; m_idx = 0;
        check_model("simul");

        // fill the buffer, then ENTER must be refused
        clear_key();
        for (int i = 0; i < 10; i++) do_enter(2'b00, 32'h100 + 32'(i), i % 4);
        next_key();
        do_enter(2'b00, 32'hFFFF, 0);
        check_model("full");

        // CLEAR during WAIT, then a late fsm_ready
        clear_key();
        s0 = starts;
        r0 = resets;
        press(3'b010, 5'b0);
        repeat (2) @(negedge clk);
        press(3'b100, 5'b10001);
        chk("abort.reset", 32'(fsm_reset), 32'(1));
        fsm_ready = 1'b1; fsm_result = 32'h55555555;
        @(negedge clk);
        fsm_ready = 1'b0; fsm_result = 32'h0;
        @(negedge clk);
        m_clear();
        chk("abort.resets", 32'(resets), 32'(r0 + 1));
        chk("abort.busy", 32'(busy), 32'(0));
        check_model("abort");

        // timeout with no response
        do_enter(2'b00, 32'h77, 1);
        digit(4'h5);
        r0 = resets;
        press(3'b010, 5'b0);
        bc = 0;
        guard = 0;
        while (busy && guard < 100) begin
            bc++;
            guard++;
            @(negedge clk);
        end
        chk("tmo.bounded", 32'(guard < 100), 32'(1));
        chk("tmo.reset", 32'(fsm_reset), 32'(1));
        @(negedge clk);
        chk("tmo.busy_cycles", 32'(bc), 32'(17));
        chk("tmo.resets", 32'(resets), 32'(r0 + 1));
        m_clear();
        m_err = 2'b11;
        check_model("tmo");

        // random operations against the model
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [1:0] e;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                digit(4'($urandom_range(0, 15)));
            end else if (r <= 6) begin
                e = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                do_enter(e, $urandom, $urandom_range(0, 10));
            end else if (r <= 8 || $urandom_range(0, 2) != 0) begin
                next_key();
            end else begin
                clear_key();
            end
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
